// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared border modes, FSM states and helpers for the KxK window buffer
package window_pkg;

  localparam logic MODE_VALID = 1'b0;
  localparam logic MODE_SAME  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } win_state_t;

  // Half-width of an odd kernel: number of zero columns padded on each side in SAME mode.
  function automatic int half_width(input int k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/window_buffer_kxk_if.sv
// rtl/window_buffer_kxk_if.sv - column-in / window-out stream bundle for the KxK window buffer
interface window_buffer_kxk_if #(
  parameter int K  = 3,
  parameter int DW = 8
);

  logic               mode_i;
  logic               valid_i;
  logic               ready_o;
  logic [K*DW-1:0]    rows_i;
  logic               valid_o;
  logic [K*K*DW-1:0]  window_o;
  logic               eol_o;
  logic               eof_o;

  modport master (
    output mode_i, valid_i, rows_i,
    input  ready_o, valid_o, window_o, eol_o, eof_o
  );

  modport slave (
    input  mode_i, valid_i, rows_i,
    output ready_o, valid_o, window_o, eol_o, eof_o
  );

endinterface

// File: rtl/window_col_shifter.sv
// rtl/window_col_shifter.sv - KxK register array that shifts one column in from the right
module window_col_shifter #(
  parameter int K  = 3,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              load_first,
  input  logic [K*DW-1:0]   col_in,
  output logic [K*K*DW-1:0] win
);

  // Element (r,c) lives at (r*K+c)*DW; column K-1 always takes the incoming column,
  // older columns either move left or are cleared at line start.
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          if (load_first) begin
            win[(r*K+c)*DW +: DW] <= '0;
          end else begin
            win[(r*K+c)*DW +: DW] <= win[(r*K+c+1)*DW +: DW];
          end
        end
        win[(r*K+K-1)*DW +: DW] <= col_in[r*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/window_buffer_kxk.sv
// rtl/window_buffer_kxk.sv - KxK sliding-window generator with VALID/SAME border modes
module window_buffer_kxk
  import window_pkg::*;
#(
  parameter int K    = 3,
  parameter int DW   = 8,
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  window_buffer_kxk_if.slave   bus
);

  localparam int R  = half_width(K);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = (R > 1) ? $clog2(R) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [FW-1:0] FLSH_LAST = FW'(R - 1);
  localparam logic [CW-1:0] THR_VALID = CW'(K - 1);
  localparam logic [CW-1:0] THR_SAME  = CW'(R);

  win_state_t      state_q, state_d;
  logic [CW-1:0]   col_cnt;
  logic [RW-1:0]   row_cnt;
  logic [FW-1:0]   flush_cnt;
  logic            mode_q;

  logic            accept;
  logic            flushing;
  logic            eff_mode;
  logic            last_col;
  logic            last_row;
  logic            last_flush;
  logic [CW-1:0]   emit_thr;
  logic            emit;
  logic            eol_evt;
  logic [K*DW-1:0] col_in;

  assign bus.ready_o = !rst && (state_q != FLUSH);
  assign accept      = bus.valid_i && bus.ready_o;
  assign flushing    = (state_q == FLUSH);
  assign last_col    = (col_cnt == COL_LAST);
  assign last_row    = (row_cnt == ROW_LAST);
  assign last_flush  = (flush_cnt == FLSH_LAST);

  // The first beat of a frame must already obey the mode it is latching.
  assign eff_mode = (state_q == IDLE) ? bus.mode_i : mode_q;

  always_comb begin
    state_d  = state_q;
    emit_thr = (eff_mode == MODE_SAME) ? THR_SAME : THR_VALID;
    emit     = (accept && (col_cnt >= emit_thr)) || flushing;
    eol_evt  = (accept && last_col && (eff_mode == MODE_VALID)) ||
               (flushing && last_flush);
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (accept && last_col) begin
          if (mode_q == MODE_SAME) state_d = FLUSH;
          else if (last_row)       state_d = IDLE;
        end
      end
      FLUSH: begin
        if (last_flush) state_d = last_row ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt     <= '0;
      row_cnt     <= '0;
      flush_cnt   <= '0;
      mode_q      <= MODE_VALID;
      bus.valid_o <= 1'b0;
      bus.eol_o   <= 1'b0;
      bus.eof_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && (state_q == IDLE)) mode_q <= bus.mode_i;
      if (accept)   col_cnt   <= last_col   ? '0 : col_cnt + 1'b1;
      if (flushing) flush_cnt <= last_flush ? '0 : flush_cnt + 1'b1;
      if (eol_evt)  row_cnt   <= last_row   ? '0 : row_cnt + 1'b1;
      bus.valid_o <= emit;
      bus.eol_o   <= eol_evt;
      bus.eof_o   <= eol_evt && last_row;
    end
  end

  // Flush cycles shift zeros in to form the right-edge padding.
  assign col_in = flushing ? '0 : bus.rows_i;

  window_col_shifter #(
    .K  (K),
    .DW (DW)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (accept || flushing),
    .load_first (accept && (col_cnt == '0)),
    .col_in     (col_in),
    .win        (bus.window_o)
  );

endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb/tb_window_buffer_kxk.sv - scoreboard bench for window_buffer_kxk (K=3 and K=5 instances)
module tb_window_buffer_kxk;
  import window_pkg::*;

  typedef struct packed {
    logic [199:0] win;
    logic         eol;
    logic         eof;
  } exp_t;

  typedef struct {
    string        name;
    logic [199:0] act;
    logic [199:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window_buffer_kxk_if #(.K(3), .DW(8)) ifa ();
  window_buffer_kxk_if #(.K(5), .DW(8)) ifb ();

  window_buffer_kxk #(.K(3), .DW(8), .COLS(5), .ROWS(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  window_buffer_kxk #(.K(5), .DW(8), .COLS(6), .ROWS(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  exp_t       qa[$];
  exp_t       qb[$];
  chk_t       cq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       done    = 1'b0;
  int         kk[2]   = '{3, 5};
  int         cc[2]   = '{5, 6};
  int         pend[2] = '{0, 0};
  logic [7:0] pix[0:5][0:4];

  function automatic logic [199:0] get_win(input int w);
    if (w == 0) return {128'b0, ifa.window_o};
    return ifb.window_o;
  endfunction

  function automatic logic get_valid(input int w);
    return (w == 0) ? ifa.valid_o : ifb.valid_o;
  endfunction

  function automatic logic get_ready(input int w);
    return (w == 0) ? ifa.ready_o : ifb.ready_o;
  endfunction

  // Window whose leftmost column is image column 'start'; columns outside the line read as 0.
  function automatic logic [199:0] build_win(input int k, input int cols, input int start);
    logic [199:0] wv;
    int col;
    wv = '0;
    for (int r = 0; r < k; r++) begin
      for (int c = 0; c < k; c++) begin
        col = start + c;
        if (col >= 0 && col < cols) wv[(r*k+c)*8 +: 8] = pix[col][r];
      end
    end
    return wv;
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    chk_t ch;
    ch.name = name;
    ch.act  = act;
    ch.exp  = exp;
    cq.push_back(ch);
  endtask

  task automatic drive(input int w, input logic v, input logic [39:0] rows, input logic m);
    if (w == 0) begin
      ifa.valid_i = v; ifa.rows_i = rows[23:0]; ifa.mode_i = m;
    end else begin
      ifb.valid_i = v; ifb.rows_i = rows;       ifb.mode_i = m;
    end
  endtask

  task automatic push_line(input int w, input logic m, input logic last);
    int   k, cols, first, nwin;
    exp_t e;
    k    = kk[w];
    cols = cc[w];
    if (m == MODE_SAME) begin
      first = -((k - 1) / 2);
      nwin  = cols;
    end else begin
      first = 0;
      nwin  = cols - k + 1;
    end
    for (int i = 0; i < nwin; i++) begin
      e.win = build_win(k, cols, first + i);
      e.eol = (i == nwin - 1);
      e.eof = e.eol && last;
      if (w == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic beat(input int w, input logic [39:0] rows, input logic m, output int waits);
    logic acc;
    int   n;
    n = 0;
    drive(w, 1'b1, rows, m);
    do begin
      acc = get_ready(w);
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 64);
    if (!acc) check("accept_timeout", 200'(0), 200'(1));
    waits = n - 1;
    drive(w, 1'b0, rows, m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
    for (int i = 0; i < 2; i++) pend[i] = (pend[i] > n) ? pend[i] - n : 0;
  endtask

  task automatic do_reset(input int remain);
    drive(0, 1'b0, 40'd0, 1'b0);
    drive(1, 1'b0, 40'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid_o",  200'(ifa.valid_o), 200'(0));
    check("rst_window_o", get_win(0), 200'(0));
    check("rst_eol_eof",  200'({ifa.eol_o, ifa.eof_o}), 200'(0));
    check("rst_ready_o",  200'(ifa.ready_o), 200'(0));
    check("rst_windows_left", 200'(qa.size()), 200'(remain));
    qa.delete();
    qb.delete();
    pend[0] = 0;
    pend[1] = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready_o", 200'(ifa.ready_o), 200'(1));
  endtask

  task automatic send_frame(input int w, input logic m, input bit rnd,
                            input int stall_col, input int rst_col);
    int          k, cols, waits, exp_w;
    logic [39:0] rows;
    k    = kk[w];
    cols = cc[w];
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < cols; c++)
        for (int r = 0; r < k; r++)
          pix[c][r] = rnd ? 8'($urandom) : 8'(16*r + c + 100*l);
      push_line(w, m, l == 1);
      for (int c = 0; c < cols; c++) begin
        if (l == 0 && c == rst_col) begin
          do_reset(cols - c);
          return;
        end
        if (l == 0 && c == stall_col) begin
          drive(w, 1'b0, 40'd0, m);
          repeat (3) begin
            @(posedge clk); #1;
            check("stall_valid_o", 200'(get_valid(w)), 200'(0));
            check("stall_hold",    get_win(w), build_win(k, cols, c - k));
          end
        end
        rows = '0;
        for (int r = 0; r < k; r++) rows[r*8 +: 8] = pix[c][r];
        exp_w   = (c == 0) ? pend[w] : 0;
        pend[w] = 0;
        beat(w, rows, (l == 0 && c == 0) ? m : 1'($urandom), waits);
        check("ready_wait", 200'(waits), 200'(exp_w));
      end
      pend[w] = (m == MODE_SAME) ? (k - 1) / 2 : 0;
    end
  endtask

  // Monitor: owns the counters, drains directed checks and scores every emitted window.
  exp_t ea, ga;
  chk_t ch;
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      ch = cq.pop_front();
      n_tests++;
      if (ch.act !== ch.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", ch.name, ch.act, ch.exp);
      end
    end
    if (ifa.valid_o === 1'b1) begin
      n_tests++;
      ga.win = get_win(0); ga.eol = ifa.eol_o; ga.eof = ifa.eof_o;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_window: unexpected window %0h eol=%b eof=%b", ga.win, ga.eol, ga.eof);
      end else begin
        ea = qa.pop_front();
        if (ga !== ea) begin
          n_fail++;
          $display("FAIL a_window: got %0h eol=%b eof=%b, expected %0h eol=%b eof=%b",
                   ga.win, ga.eol, ga.eof, ea.win, ea.eol, ea.eof);
        end
      end
    end
    if (ifb.valid_o === 1'b1) begin
      n_tests++;
      ga.win = get_win(1); ga.eol = ifb.eol_o; ga.eof = ifb.eof_o;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_window: unexpected window %0h eol=%b eof=%b", ga.win, ga.eol, ga.eof);
      end else begin
        ea = qb.pop_front();
        if (ga !== ea) begin
          n_fail++;
          $display("FAIL b_window: got %0h eol=%b eof=%b, expected %0h eol=%b eof=%b",
                   ga.win, ga.eol, ga.eof, ea.win, ea.eol, ea.eof);
        end
      end
    end
    if (done) begin
      n_tests++;
      if (qa.size() != 0 || qb.size() != 0) begin
        n_fail++;
        $display("FAIL missing_windows: a left %0d, b left %0d, expected 0 and 0", qa.size(), qb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: end of stimulus not reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 1'b0, 40'd0, 1'b0);
    drive(1, 1'b0, 40'd0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_a",  200'(ifa.ready_o), 200'(0));
    check("reset_ready_b",  200'(ifb.ready_o), 200'(0));
    check("reset_valid_a",  200'(ifa.valid_o), 200'(0));
    check("reset_window_a", get_win(0), 200'(0));
    check("reset_window_b", get_win(1), 200'(0));
    check("reset_eol_eof",  200'({ifa.eol_o, ifa.eof_o, ifb.eol_o, ifb.eof_o}), 200'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst_a", 200'(ifa.ready_o), 200'(1));
    check("ready_after_rst_b", 200'(ifb.ready_o), 200'(1));

    send_frame(0, MODE_VALID, 1'b0, -1, -1);
    send_frame(0, MODE_SAME,  1'b0, -1, -1);
    send_frame(0, MODE_SAME,  1'b1, -1, -1);
    send_frame(0, MODE_VALID, 1'b0,  3, -1);
    send_frame(1, MODE_SAME,  1'b0, -1, -1);
    idle(4);
    send_frame(1, MODE_SAME,  1'b1, -1, -1);
    send_frame(1, MODE_VALID, 1'b1, -1, -1);
    send_frame(1, MODE_SAME,  1'b1, -1, -1);
    send_frame(0, MODE_VALID, 1'b0, -1,  4);
    send_frame(0, MODE_VALID, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++) send_frame(0, 1'($urandom), 1'b1, -1, -1);
    idle(10);
    done = 1'b1;
  end

endmodule
